rolha_estoque: RTL and testbench

Cork reservoir manager that sits between the cork dispenser state machine and the capping station. It tracks the number of corks in the reservoir:
- adds one cork per rising edge of the dispenser's add_rolha;
- hands one cork to the capping station per bottle request while the dispenser is in its dispensing state.

It produces the rolha5 stock flag that the dispenser consumes, plus empty/full status and the stock count for display.

---
 rtl/rolha_estoque.sv | 135 +++++++++++++
 tb/tb_rolha_estoque.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rolha_estoque.sv
// Cork reservoir manager: counts corks added by the dispenser and hands one to the capping station per request.
// Latency: stock and status flags update one cycle after add edge / request; rolha_out is high for DELIVER_CYCLES cycles.
// Backpressure: a request is held until disp=1 and stock>0; after delivery it must drop before the next cork is served.
// Optional macro ROLHA_BCD_EN adds registered BCD outputs dezena/unidade for a 7-segment display.
module rolha_estoque #(
   parameter int WIDTH          = 5,
   parameter int MAX_STOCK      = 20,
   parameter int LOW_LEVEL      = 5,
   parameter int DELIVER_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             add_rolha,
   input  logic             disp,
   input  logic             pedido_rolha,
   output logic             rolha_out,
   output logic             entregue,
   output logic             rolha5,
   output logic             vazio,
   output logic             cheio,
   output logic [WIDTH-1:0] estoque
`ifdef ROLHA_BCD_EN
   ,
   output logic [3:0]       dezena,
   output logic [3:0]       unidade
`endif
);

   localparam int TW = (DELIVER_CYCLES > 1) ? $clog2(DELIVER_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DELIVER  = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   state_t           state;
   logic [TW-1:0]    timer;
   logic             add_prev;
   logic             add_ev;
   logic             take_ev;
   logic [WIDTH-1:0] estoque_nxt;

   // Rising edge of add_rolha; take is only possible from IDLE with stock available
   always_comb begin
      add_ev      = add_rolha & ~add_prev;
      take_ev     = (state == IDLE) & pedido_rolha & disp & (estoque != '0);
      estoque_nxt = estoque;
      if (add_ev && !take_ev) begin
         // saturate at capacity: extra corks are ignored
         if (estoque != WIDTH'(MAX_STOCK))
            estoque_nxt = estoque + WIDTH'(1);
      end else if (take_ev && !add_ev) begin
         estoque_nxt = estoque - WIDTH'(1);
      end
   end

   // Stock counter and flags computed from the next value so they align with estoque
   always_ff @(posedge clk) begin
      if (reset) begin
         add_prev <= 1'b0;
         estoque  <= '0;
         rolha5   <= 1'b0;
         vazio    <= 1'b1;
         cheio    <= 1'b0;
      end else begin
         add_prev <= add_rolha;
         estoque  <= estoque_nxt;
         rolha5   <= (estoque_nxt >= WIDTH'(LOW_LEVEL));
         vazio    <= (estoque_nxt == '0);
         cheio    <= (estoque_nxt == WIDTH'(MAX_STOCK));
      end
   end

   // Delivery FSM; entregue is raised on entry to the last DELIVER cycle so it
   // coincides with the DELIVER->WAIT_REL transition cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         rolha_out <= 1'b0;
         entregue  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rolha_out <= 1'b0;
               entregue  <= 1'b0;
               if (take_ev) begin
                  state     <= DELIVER;
                  timer     <= TW'(DELIVER_CYCLES - 1);
                  rolha_out <= 1'b1;
                  entregue  <= (DELIVER_CYCLES == 1);
               end
            end
            DELIVER: begin
               // disp is ignored here: the cork is already committed
               if (timer == '0) begin
                  state     <= WAIT_REL;
                  rolha_out <= 1'b0;
                  entregue  <= 1'b0;
               end else begin
                  timer     <= timer - TW'(1);
                  rolha_out <= 1'b1;
                  entregue  <= (timer == TW'(1));
               end
            end
            WAIT_REL: begin
               rolha_out <= 1'b0;
               entregue  <= 1'b0;
               if (!pedido_rolha)
                  state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               rolha_out <= 1'b0;
               entregue  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ROLHA_BCD_EN
   // Display digits lag estoque by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         dezena  <= 4'd0;
         unidade <= 4'd0;
      end else begin
         dezena  <= 4'(int'(estoque) / 10);
         unidade <= 4'(int'(estoque) % 10);
      end
   end
`endif

endmodule

// File: tb/tb_rolha_estoque.sv
// Bench for rolha_estoque: directed stimulus, behavioural reservoir model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_rolha_estoque;

   logic       clk = 1'b0;
   logic       reset;
   logic       add_rolha;
   logic       disp;
   logic       pedido_rolha;
   logic       rolha_out;
   logic       entregue;
   logic       rolha5;
   logic       vazio;
   logic       cheio;
   logic [4:0] estoque;

   int total = 0;
   int bad   = 0;
   int n_out = 0;
   int n_ent = 0;

   // reservoir model: cork count, remaining release cycles, waiting-for-release flag
   int m_stock = 0;
   int m_left  = 0;
   bit m_wait  = 1'b0;
   bit m_prev  = 1'b0;
   bit m_valid = 1'b0;

   rolha_estoque dut (
      .clk(clk), .reset(reset), .add_rolha(add_rolha), .disp(disp),
      .pedido_rolha(pedido_rolha), .rolha_out(rolha_out), .entregue(entregue),
      .rolha5(rolha5), .vazio(vazio), .cheio(cheio), .estoque(estoque)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bit add, take;
      if (reset) begin
         m_stock = 0; m_left = 0; m_wait = 1'b0; m_prev = 1'b0; m_valid = 1'b1;
      end else begin
         add    = add_rolha && !m_prev;
         m_prev = add_rolha;
         take   = (m_left == 0) && !m_wait && pedido_rolha && disp && (m_stock > 0);
         if (add && !take && m_stock < 20) m_stock++;
         else if (take && !add) m_stock--;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_wait = 1'b1;
         end else if (m_wait) begin
            if (!pedido_rolha) m_wait = 1'b0;
         end else if (take) begin
            m_left = 3;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // advance n cycles, comparing DUT against model after each edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         if (rolha_out) n_out++;
         if (entregue)  n_ent++;
         if (m_valid) begin
            chk("estoque",   int'(estoque),   m_stock);
            chk("rolha_out", int'(rolha_out), int'(m_left > 0));
            chk("entregue",  int'(entregue),  int'(m_left == 1));
            chk("rolha5",    int'(rolha5),    int'(m_stock >= 5));
            chk("vazio",     int'(vazio),     int'(m_stock == 0));
            chk("cheio",     int'(cheio),     int'(m_stock == 20));
         end
      end
   endtask

   task automatic pulse();
      add_rolha = 1'b1; tick(2);
      add_rolha = 1'b0; tick(2);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; add_rolha = 1'b0; disp = 1'b0; pedido_rolha = 1'b0;
      tick(2);
      chk("rst_estoque", int'(estoque), 0);
      chk("rst_vazio",   int'(vazio),   1);
      chk("rst_rolha5",  int'(rolha5),  0);
      chk("rst_out",     int'(rolha_out), 0);
      reset = 1'b0;
      tick(1);

      // five add pulses, rolha5 exactly at 5
      pulse();
      chk("vazio_after_add", int'(vazio), 0);
      for (int i = 0; i < 3; i++) pulse();
      chk("rolha5_at4", int'(rolha5), 0);
      pulse();
      chk("estoque_5", int'(estoque), 5);
      chk("rolha5_at5", int'(rolha5), 1);

      // held level counts once
      add_rolha = 1'b1; tick(10);
      add_rolha = 1'b0; tick(2);
      chk("held_add", int'(estoque), 6);

      // fill to capacity then saturate
      for (int i = 0; i < 14; i++) pulse();
      chk("full", int'(estoque), 20);
      chk("cheio", int'(cheio), 1);
      pulse();
      chk("sat", int'(estoque), 20);
      chk("cheio_sat", int'(cheio), 1);

      // add held across reset release counts as an edge
      reset = 1'b1; add_rolha = 1'b1; tick(1);
      reset = 1'b0; tick(1);
      chk("add_after_rst", int'(estoque), 1);
      add_rolha = 1'b0; tick(1);

      // single delivery from stock 5
      do_reset();
      for (int i = 0; i < 5; i++) pulse();
      n_out = 0; n_ent = 0;
      disp = 1'b1; pedido_rolha = 1'b1; tick(8);
      pedido_rolha = 1'b0; tick(3);
      chk("out_cycles", n_out, 3);
      chk("ent_pulses", n_ent, 1);
      chk("after_take", int'(estoque), 4);
      chk("rolha5_after", int'(rolha5), 0);

      // request while empty, served after one add
      do_reset();
      n_out = 0; n_ent = 0;
      disp = 1'b1; pedido_rolha = 1'b1; tick(3);
      chk("empty_no_out", n_out, 0);
      add_rolha = 1'b1; tick(1);
      chk("one_cork", int'(estoque), 1);
      add_rolha = 1'b0; tick(1);
      chk("deliver_start", int'(rolha_out), 1);
      tick(5);
      pedido_rolha = 1'b0; tick(2);
      chk("empty_end", int'(estoque), 0);
      chk("empty_vazio", int'(vazio), 1);
      chk("empty_ent", n_ent, 1);

      // add and take in the same cycle, then reset mid-delivery
      do_reset();
      for (int i = 0; i < 7; i++) pulse();
      add_rolha = 1'b1; pedido_rolha = 1'b1; tick(1);
      chk("coincide", int'(estoque), 7);
      chk("coincide_out", int'(rolha_out), 1);
      add_rolha = 1'b0; tick(1);
      reset = 1'b1; tick(1);
      chk("abort_out", int'(rolha_out), 0);
      chk("abort_estoque", int'(estoque), 0);
      chk("abort_vazio", int'(vazio), 1);
      chk("abort_ent", int'(entregue), 0);
      reset = 1'b0; pedido_rolha = 1'b0; tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
